palette_loader: RTL and testbench
=================================

Name: palette_loader

Overview:
- Runtime writer for the colour-palette RAM that the iteration-to-RGB lookup stage reads from.
- Takes a stream of packed RGB words from the host (valid/ready/last) after a start pulse.
- Writes them sequentially into palette addresses 0..LUT_SIZE-1.
- Reports when the palette is complete and consistent, so colouring can be gated on palette_valid.

Parameters:
- RBG_SIZE, 24, width of one palette entry (RGB888).
- LUT_SIZE, 256, number of palette entries; must be a power of two ≥ 2.
- ADDR_WIDTH, 8, palette address width; equals log2(LUT_SIZE).
- DATA_WIDTH, 32, input stream word width; must be ≥ RBG_SIZE.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a palette load. Honoured only in IDLE, DONE or ERR.
- abort  input  1  returns the FSM to IDLE from any state on the next edge.
- s_data  input  DATA_WIDTH  stream word; bits [RBG_SIZE-1:0] are the entry; upper bits are ignored.
- s_valid  input  1  stream word valid.
- s_last  input  1  marks the final word of the host's transfer.
- s_ready  output  1  loader accepts a word this cycle.
- wr_en  output  1  palette RAM write strobe.
- wr_addr  output  ADDR_WIDTH  palette RAM write address.
- wr_data  output  RBG_SIZE  palette RAM write data.
- busy  output  1  high in LOAD.
- palette_valid  output  1  level; a complete palette has been written.
- err  output  1  sticky; the last load terminated early.

Behaviour:
- Reset (async, active-high): state = IDLE; s_ready, wr_en, busy, palette_valid, err = 0; wr_addr, wr_data = 0; internal entry counter = 0.
- State register encodes IDLE, LOAD, DONE, ERR.
- s_ready is a registered-state decode: 1 only in LOAD, 0 otherwise. It does not depend combinationally on s_valid.
- IDLE → LOAD on start:
  - counter ← 0, palette_valid ← 0, err ← 0.
  - busy rises on the next cycle.
- LOAD accept rule: a word is accepted on any edge where s_valid & s_ready.
  - Next cycle (fixed 1-cycle latency): wr_en = 1, wr_addr = counter value at accept, wr_data = s_data[RBG_SIZE-1:0].
  - Otherwise wr_en = 0; wr_addr and wr_data hold their last values.
- Counter increments by 1 per accepted word, ADDR_WIDTH+1 bits wide; no wrap inside a load.
- Completion: accepting the word at counter = LUT_SIZE-1 → DONE, whether or not s_last is set.
  - palette_valid ← 1 in the same edge that issues the final write.
- Early end: s_last accepted with counter < LUT_SIZE-1 → that word is still written, then ERR.
  - err ← 1, palette_valid stays 0.
- DONE and ERR: s_ready = 0; words offered here are not consumed.
  - start re-enters LOAD, clearing palette_valid and err.
- start while in LOAD is ignored; the load continues.
- abort in any state → IDLE next edge:
  - palette_valid ← 0, err unchanged.
  - No write is issued for a word offered in the abort cycle.
  - A write already registered from the previous accept still completes.
- abort and start in the same cycle: abort wins.
- Back-to-back: one word per cycle is sustained while s_valid stays high; a full load takes LUT_SIZE accept cycles plus 1 write-latency cycle.
- rst mid-load: all outputs return to reset values immediately. Partial palette RAM contents are left as-is; palette_valid = 0 marks them unusable.

Test Plan:
- rst, start, then 256 consecutive words 0x00000000..0x000000FF, s_last on the last → 256 writes, addr 0..255 with data = addr; palette_valid = 1 one cycle after the final accept; err = 0; s_ready low afterwards.
- Words with upper byte 0xAB (e.g. 0xAB123456) → wr_data = 0x123456.
- Random s_valid gaps (≈50% duty) → exactly 256 writes in order, each 1 cycle after its handshake.
- s_last on word 99 → 100 writes (addr 0..99), state ERR, err = 1, palette_valid = 0; a new start clears err.
- abort asserted after 40 accepts while s_valid is high → no write for the abort-cycle word, IDLE, palette_valid = 0, s_ready = 0.
- start while in LOAD at counter 10 → ignored, counter continues to 11. rst pulse at counter 128 → all outputs 0 immediately; a subsequent start loads from addr 0.

Source files
------------

// File: rtl/palette_loader_if.sv
// Host stream and palette RAM write port of the palette loader.
// The host/bench side uses master; the loader uses slave.
interface palette_loader_if #(
   parameter int RBG_SIZE   = 24,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic                  abort;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_valid;
   logic                  s_last;
   logic                  s_ready;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [RBG_SIZE-1:0]   wr_data;
   logic                  busy;
   logic                  palette_valid;
   logic                  err;

   modport master (
      output start, abort, s_data, s_valid, s_last,
      input  s_ready, wr_en, wr_addr, wr_data, busy, palette_valid, err
   );

   modport slave (
      input  start, abort, s_data, s_valid, s_last,
      output s_ready, wr_en, wr_addr, wr_data, busy, palette_valid, err
   );
endinterface

// File: rtl/palette_loader.sv
// Streams host RGB words into palette RAM addresses 0..LUT_SIZE-1 and flags
// whether the palette is complete (palette_valid) or the load ended early (err).
//
// state | meaning
// IDLE  | no load in progress, palette_valid low
// LOAD  | accepting stream words, one write per accepted word
// DONE  | all LUT_SIZE entries written, palette usable
// ERR   | host ended its transfer before the palette was full
module palette_loader #(
   parameter int RBG_SIZE   = 24,
   parameter int LUT_SIZE   = 256,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input logic             clk,
   input logic             rst,
   palette_loader_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

   localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(LUT_SIZE - 1);
   localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);

   state_t                state;
   logic [ADDR_WIDTH:0]   cnt;
   logic                  s_ready_q;
   logic                  busy_q;
   logic                  pv_q;
   logic                  err_q;
   logic                  wr_en_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [RBG_SIZE-1:0]   wr_data_q;
   logic                  accept;

   // s_ready is a registered copy of (state == LOAD), so accept never loops
   // combinationally back through s_valid.
   assign accept = bus.s_valid & s_ready_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         s_ready_q <= 1'b0;
         busy_q    <= 1'b0;
         pv_q      <= 1'b0;
         err_q     <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= 1'b0;
         if (bus.abort) begin
            // A write registered last cycle still reaches the RAM this cycle;
            // the word offered now is dropped.
            state     <= IDLE;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            pv_q      <= 1'b0;
         end else begin
            case (state)
               IDLE, DONE, ERR: begin
                  if (bus.start) begin
                     state     <= LOAD;
                     cnt       <= '0;
                     pv_q      <= 1'b0;
                     err_q     <= 1'b0;
                     s_ready_q <= 1'b1;
                     busy_q    <= 1'b1;
                  end
               end
               LOAD: begin
                  if (accept) begin
                     wr_en_q   <= 1'b1;
                     wr_addr_q <= cnt[ADDR_WIDTH-1:0];
                     wr_data_q <= bus.s_data[RBG_SIZE-1:0];
                     cnt       <= cnt + CNT_ONE;
                     if (cnt == LAST_IDX) begin
                        state     <= DONE;
                        pv_q      <= 1'b1;
                        s_ready_q <= 1'b0;
                        busy_q    <= 1'b0;
                     end else if (bus.s_last) begin
                        state     <= ERR;
                        err_q     <= 1'b1;
                        s_ready_q <= 1'b0;
                        busy_q    <= 1'b0;
                     end
                  end
               end
               default: begin
                  state     <= IDLE;
                  s_ready_q <= 1'b0;
                  busy_q    <= 1'b0;
               end
            endcase
         end
      end
   end

   generate
      if (DATA_WIDTH > RBG_SIZE) begin : g_pad
         logic unused_pad;
         assign unused_pad = ^bus.s_data[DATA_WIDTH-1:RBG_SIZE];
      end
   endgenerate

   assign bus.s_ready       = s_ready_q;
   assign bus.busy          = busy_q;
   assign bus.palette_valid = pv_q;
   assign bus.err           = err_q;
   assign bus.wr_en         = wr_en_q;
   assign bus.wr_addr       = wr_addr_q;
   assign bus.wr_data       = wr_data_q;
endmodule

// File: tb/tb_palette_loader.sv
// Directed/randomized bench for palette_loader against a word-count based model.
module tb_palette_loader;
   logic clk;
   logic rst;

   palette_loader_if #(.RBG_SIZE(24), .ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

   palette_loader #(.RBG_SIZE(24), .LUT_SIZE(256), .ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total;
   int bad;

   // reference model: loading flag, words taken this load, flags, last write
   bit          m_load;
   int          m_n;
   bit          m_pv;
   bit          m_er;
   bit          m_wr;
   logic [7:0]  m_addr;
   logic [23:0] m_data;
   int          o_writes;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("s_ready", 32'(bus.s_ready), 32'(m_load));
      chk("busy", 32'(bus.busy), 32'(m_load));
      chk("palette_valid", 32'(bus.palette_valid), 32'(m_pv));
      chk("err", 32'(bus.err), 32'(m_er));
      chk("wr_en", 32'(bus.wr_en), 32'(m_wr));
      chk("wr_addr", 32'(bus.wr_addr), 32'(m_addr));
      chk("wr_data", 32'(bus.wr_data), 32'(m_data));
      if (bus.wr_en === 1'b1) o_writes++;
   endtask

   task automatic step(input bit v, input logic [31:0] d, input bit l, input bit st, input bit ab);
      bit was_load;
      bit acc;
      @(negedge clk);
      bus.s_valid = v;
      bus.s_data  = d;
      bus.s_last  = l;
      bus.start   = st;
      bus.abort   = ab;
      was_load = m_load;
      acc      = v && m_load;
      @(posedge clk);
      #1;
      m_wr = 1'b0;
      if (ab) begin
         m_load = 1'b0;
         m_pv   = 1'b0;
      end else if (acc) begin
         m_wr   = 1'b1;
         m_addr = 8'(m_n);
         m_data = d[23:0];
         m_n++;
         if (m_n == 256) begin
            m_load = 1'b0;
            m_pv   = 1'b1;
         end else if (l) begin
            m_load = 1'b0;
            m_er   = 1'b1;
         end
      end else if (st && !was_load) begin
         m_load = 1'b1;
         m_n    = 0;
         m_pv   = 1'b0;
         m_er   = 1'b0;
      end
      check_outputs();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.abort   = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      bus.s_data  = '0;
      #1;
      m_load = 1'b0;
      m_n    = 0;
      m_pv   = 1'b0;
      m_er   = 1'b0;
      m_wr   = 1'b0;
      m_addr = '0;
      m_data = '0;
      check_outputs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] r;
      int          i;
      bit          v;
      clk = 1'b0;
      rst = 1'b1;
      total = 0;
      bad   = 0;
      o_writes = 0;
      bus.start = 1'b0; bus.abort = 1'b0; bus.s_valid = 1'b0;
      bus.s_last = 1'b0; bus.s_data = '0;
      do_reset();
      step(0, 32'h0, 0, 0, 0);

      // full contiguous load, data = address, s_last on the final word
      o_writes = 0;
      step(0, 32'h0, 0, 1, 0);
      for (int k = 0; k < 256; k++) step(1, 32'(k), k == 255, 0, 0);
      step(0, 32'h0, 0, 0, 0);
      step(1, 32'h55, 1, 0, 0);
      chk("writes_full", 32'(o_writes), 32'd256);

      // upper byte 0xAB must be stripped; no s_last on the final word
      o_writes = 0;
      step(0, 32'h0, 0, 1, 0);
      for (int k = 0; k < 256; k++) begin
         r = $urandom;
         step(1, {8'hAB, r[23:0]}, 0, 0, 0);
      end
      step(0, 32'hAB123456, 0, 0, 0);
      chk("writes_ab", 32'(o_writes), 32'd256);

      // random valid gaps
      o_writes = 0;
      step(0, 32'h0, 0, 1, 0);
      i = 0;
      while (i < 256) begin
         v = 1'($urandom_range(0, 1));
         r = $urandom;
         step(v, r, i == 255, 0, 0);
         if (v) i++;
      end
      step(0, 32'h0, 0, 0, 0);
      chk("writes_gaps", 32'(o_writes), 32'd256);

      // early s_last on word 99
      o_writes = 0;
      step(0, 32'h0, 0, 1, 0);
      for (int k = 0; k < 100; k++) step(1, $urandom, k == 99, 0, 0);
      step(1, $urandom, 0, 0, 0);
      step(1, $urandom, 1, 0, 0);
      chk("writes_early", 32'(o_writes), 32'd100);
      chk("err_sticky", 32'(bus.err), 32'd1);
      step(0, 32'h0, 0, 1, 0);

      // abort after 40 accepts while s_valid stays high
      o_writes = 0;
      for (int k = 0; k < 40; k++) step(1, $urandom, 0, 0, 0);
      step(1, $urandom, 0, 0, 1);
      step(1, $urandom, 0, 0, 0);
      chk("writes_abort", 32'(o_writes), 32'd40);
      step(0, 32'h0, 0, 1, 1);
      step(1, $urandom, 0, 0, 0);

      // start ignored mid-load, then rst at 128 accepts
      step(0, 32'h0, 0, 1, 0);
      for (int k = 0; k < 10; k++) step(1, $urandom, 0, 0, 0);
      step(1, $urandom, 0, 1, 0);
      for (int k = 11; k < 128; k++) step(1, $urandom, 0, 0, 0);
      do_reset();
      step(0, 32'h0, 0, 1, 0);
      for (int k = 0; k < 3; k++) step(1, $urandom, k == 2, 0, 0);
      step(0, 32'h0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
